accumulator: RTL and testbench

- Downstream stage of the parameterized adder. Consumes its registered or unregistered sum stream and accumulates ACC_LEN accepted samples into one wide result.
- Presents the result on a valid/ready output handshake.
- Sits between adder outputs and the decimation/readout logic. Provides block-sum (integrate-and-dump) behaviour with overflow reporting.

---
 rtl/accumulator_pkg.sv | 23 ++
 rtl/accumulator_add_sat.sv | 39 +++
 rtl/accumulator.sv | 113 +++++++++++
 tb/tb_accumulator.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/accumulator_pkg.sv
// Shared definitions for the accumulator: FSM state encoding, implementation
// select strings common to the adder family, and a parameter-legality helper.
package accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";
  localparam string ARCH_VIRTEX5    = "VIRTEX5";
  localparam string ARCH_VIRTEX6    = "VIRTEX6";

  // True when the width/length combination can be built: accumulator at least as
  // wide as a sample, and the sample counter able to reach ACC_LEN-1.
  function automatic bit params_legal(input int data_width, input int acc_width,
                                      input int acc_len, input int cnt_width);
    return (data_width >= 1) && (acc_width >= data_width) && (acc_len >= 1) &&
           (cnt_width >= 1) && (cnt_width < 31) &&
           ((acc_len - 1) < (1 << cnt_width));
  endfunction

endpackage

// File: rtl/accumulator_add_sat.sv
// ACC_WIDTH-bit unsigned adder with carry out. Clamps the sum to all-ones on
// carry when ACCUMULATOR_SATURATE_EN is defined, otherwise wraps.
module accumulator_add_sat
  import accumulator_pkg::*;
#(
  parameter string ARCHITECTURE = "BEHAVIORAL",
  parameter int    ACC_WIDTH    = 16
) (
  input  logic [ACC_WIDTH-1:0] a_i,
  input  logic [ACC_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 carry_o
);

  logic [ACC_WIDTH:0] raw_sum;

  generate
    if (ARCHITECTURE == ARCH_BEHAVIORAL) begin : g_behavioral
      assign raw_sum = {1'b0, a_i} + {1'b0, b_i};
    end else if ((ARCHITECTURE == ARCH_VIRTEX5) || (ARCHITECTURE == ARCH_VIRTEX6)) begin : g_dsp
      // Kept as an isolated add so the vendor flow can pack it into a DSP slice.
      logic [ACC_WIDTH:0] dsp_sum;
      assign dsp_sum = {1'b0, a_i} + {1'b0, b_i};
      assign raw_sum = dsp_sum;
    end else begin : g_bad_arch
      $error("accumulator_add_sat: unsupported ARCHITECTURE");
      assign raw_sum = '0;
    end
  endgenerate

  assign carry_o = raw_sum[ACC_WIDTH];

`ifdef ACCUMULATOR_SATURATE_EN
  assign sum_o = carry_o ? {ACC_WIDTH{1'b1}} : raw_sum[ACC_WIDTH-1:0];
`else
  assign sum_o = raw_sum[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/accumulator.sv
// Integrate-and-dump accumulator: sums ACC_LEN accepted samples and presents the
// block sum with a sticky overflow flag on a valid/ready output. Saturating
// arithmetic is selected by ACCUMULATOR_SATURATE_EN (wrapping when undefined).
module accumulator
  import accumulator_pkg::*;
#(
  parameter string ARCHITECTURE = "BEHAVIORAL",
  parameter int    DATA_WIDTH   = 9,
  parameter int    ACC_WIDTH    = 16,
  parameter int    ACC_LEN      = 16,
  parameter int    CNT_WIDTH    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  clear_i,
  output logic [ACC_WIDTH-1:0]  data_o,
  output logic                  overflow_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  generate
    if (!params_legal(DATA_WIDTH, ACC_WIDTH, ACC_LEN, CNT_WIDTH)) begin : g_bad_params
      $error("accumulator: illegal DATA_WIDTH/ACC_WIDTH/ACC_LEN/CNT_WIDTH combination");
    end
  endgenerate

  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(ACC_LEN - 1);

  acc_state_e           state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 sticky_q;
  logic [ACC_WIDTH-1:0] data_q;
  logic                 overflow_q;
  logic                 valid_q;

  logic [ACC_WIDTH-1:0] sample_ext;
  logic [ACC_WIDTH-1:0] acc_d;
  logic                 carry_d;
  logic                 sticky_d;
  logic [CNT_WIDTH-1:0] count_d;

  assign sample_ext = ACC_WIDTH'(data_i);

  accumulator_add_sat #(
    .ARCHITECTURE (ARCHITECTURE),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_add_sat (
    .a_i     (acc_q),
    .b_i     (sample_ext),
    .sum_o   (acc_d),
    .carry_o (carry_d)
  );

  assign sticky_d = sticky_q | carry_d;
  assign count_d  = count_q + CNT_WIDTH'(1);

  // Clear outranks both sample acceptance and result acceptance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      count_q    <= '0;
      sticky_q   <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else if (clear_i) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (valid_i) begin
            if (count_q == LAST_COUNT) begin
              data_q     <= acc_d;
              overflow_q <= sticky_d;
              valid_q    <= 1'b1;
              acc_q      <= '0;
              count_q    <= '0;
              sticky_q   <= 1'b0;
              state_q    <= HOLD;
            end else begin
              acc_q    <= acc_d;
              count_q  <= count_d;
              sticky_q <= sticky_d;
            end
          end
        end
        HOLD: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            state_q <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign ready_o    = (state_q == ACCUM);
  assign data_o     = data_q;
  assign overflow_o = overflow_q;
  assign valid_o    = valid_q;

endmodule

// File: tb/tb_accumulator.sv
// Directed bench for accumulator: main 4-sample instance driven from a vector
// table, plus a 10-bit overflow instance and an ACC_LEN=1 instance.
module tb_accumulator;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Instance A: ACC_WIDTH=16, ACC_LEN=4
  logic [8:0]  a_data_i  = '0;
  logic        a_valid_i = 1'b0;
  logic        a_clear_i = 1'b0;
  logic        a_ready_i = 1'b0;
  logic        a_ready_o, a_ovf_o, a_valid_o;
  logic [15:0] a_data_o;

  // Instance B: ACC_WIDTH=10, ACC_LEN=4
  logic [8:0]  b_data_i  = '0;
  logic        b_valid_i = 1'b0;
  logic        b_ready_o, b_ovf_o, b_valid_o;
  logic [9:0]  b_data_o;

  // Instance C: ACC_WIDTH=16, ACC_LEN=1
  logic [8:0]  c_data_i  = '0;
  logic        c_valid_i = 1'b0;
  logic        c_ready_o, c_ovf_o, c_valid_o;
  logic [15:0] c_data_o;

  accumulator #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH(9), .ACC_WIDTH(16),
                .ACC_LEN(4), .CNT_WIDTH(8)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(a_data_i), .valid_i(a_valid_i),
    .ready_o(a_ready_o), .clear_i(a_clear_i), .data_o(a_data_o),
    .overflow_o(a_ovf_o), .valid_o(a_valid_o), .ready_i(a_ready_i));

  accumulator #(.ARCHITECTURE("VIRTEX5"), .DATA_WIDTH(9), .ACC_WIDTH(10),
                .ACC_LEN(4), .CNT_WIDTH(8)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(b_data_i), .valid_i(b_valid_i),
    .ready_o(b_ready_o), .clear_i(1'b0), .data_o(b_data_o),
    .overflow_o(b_ovf_o), .valid_o(b_valid_o), .ready_i(1'b1));

  accumulator #(.ARCHITECTURE("VIRTEX6"), .DATA_WIDTH(9), .ACC_WIDTH(16),
                .ACC_LEN(1), .CNT_WIDTH(8)) dut_c (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(c_data_i), .valid_i(c_valid_i),
    .ready_o(c_ready_o), .clear_i(1'b0), .data_o(c_data_o),
    .overflow_o(c_ovf_o), .valid_o(c_valid_o), .ready_i(1'b1));

`ifdef ACCUMULATOR_SATURATE_EN
  localparam int B_OVF_SUM = 1023;
`else
  localparam int B_OVF_SUM = 1020;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Inputs are changed 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [8:0]  d;
    logic        clr;
    logic        rdy;
    logic        e_ready;
    logic        e_valid;
    logic        e_ovf;
    logic [15:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input int d, input logic clr, input logic rdy,
                              input logic er, input logic ev, input logic eo, input int ed);
    vec_t t;
    t.v = v; t.d = 9'(d); t.clr = clr; t.rdy = rdy;
    t.e_ready = er; t.e_valid = ev; t.e_ovf = eo; t.e_data = 16'(ed);
    return t;
  endfunction

  function automatic logic [31:0] pack_a(input logic r, input logic v, input logic o,
                                         input logic [15:0] d);
    return {13'b0, r, v, o, d};
  endfunction

  initial begin
    // Block 1..4 with ready_i high: sum 10, one-cycle valid
    vecs.push_back(mk(1, 1, 0, 1,  1, 0, 0, 0));
    vecs.push_back(mk(1, 2, 0, 1,  1, 0, 0, 0));
    vecs.push_back(mk(1, 3, 0, 1,  1, 0, 0, 0));
    vecs.push_back(mk(1, 4, 0, 1,  0, 1, 0, 10));
    vecs.push_back(mk(0, 0, 0, 1,  1, 0, 0, 10));
    // Same block, downstream stalls 5 cycles while 7s are offered
    vecs.push_back(mk(1, 1, 0, 0,  1, 0, 0, 10));
    vecs.push_back(mk(1, 2, 0, 0,  1, 0, 0, 10));
    vecs.push_back(mk(1, 3, 0, 0,  1, 0, 0, 10));
    vecs.push_back(mk(1, 4, 0, 0,  0, 1, 0, 10));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 7, 0, 0,  0, 1, 0, 10));
    vecs.push_back(mk(1, 7, 0, 1,  1, 0, 0, 10));
    // Fresh block after release: no 7 leaked in
    vecs.push_back(mk(1, 1, 0, 1,  1, 0, 0, 10));
    vecs.push_back(mk(1, 1, 0, 1,  1, 0, 0, 10));
    vecs.push_back(mk(1, 1, 0, 1,  1, 0, 0, 10));
    vecs.push_back(mk(1, 1, 0, 1,  0, 1, 0, 4));
    vecs.push_back(mk(0, 0, 0, 1,  1, 0, 0, 4));
    // 9, 9, clear with 100 presented, then 5 x4 -> 20
    vecs.push_back(mk(1, 9, 0, 1,  1, 0, 0, 4));
    vecs.push_back(mk(1, 9, 0, 1,  1, 0, 0, 4));
    vecs.push_back(mk(1, 100, 1, 1, 1, 0, 0, 4));
    vecs.push_back(mk(1, 5, 0, 1,  1, 0, 0, 4));
    vecs.push_back(mk(1, 5, 0, 1,  1, 0, 0, 4));
    vecs.push_back(mk(1, 5, 0, 1,  1, 0, 0, 4));
    vecs.push_back(mk(1, 5, 0, 1,  0, 1, 0, 20));
    vecs.push_back(mk(0, 0, 0, 1,  1, 0, 0, 20));
    // Clear while holding a result drops valid_o without ready_i
    vecs.push_back(mk(1, 2, 0, 0,  1, 0, 0, 20));
    vecs.push_back(mk(1, 2, 0, 0,  1, 0, 0, 20));
    vecs.push_back(mk(1, 2, 0, 0,  1, 0, 0, 20));
    vecs.push_back(mk(1, 2, 0, 0,  0, 1, 0, 8));
    vecs.push_back(mk(0, 0, 1, 0,  1, 0, 0, 8));
    vecs.push_back(mk(1, 6, 0, 1,  1, 0, 0, 8));

    // Initial reset
    #1 rst_i = 1'b1;
    #1;
    check("reset_a", pack_a(1'b0, a_valid_o, a_ovf_o, a_data_o), pack_a(1'b0, 1'b0, 1'b0, 16'd0));
    check("reset_ready_a", 32'(a_ready_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      a_valid_i = vecs[i].v;
      a_data_i  = vecs[i].d;
      a_clear_i = vecs[i].clr;
      a_ready_i = vecs[i].rdy;
      step();
      check($sformatf("vec%0d", i),
            pack_a(a_ready_o, a_valid_o, a_ovf_o, a_data_o),
            pack_a(vecs[i].e_ready, vecs[i].e_valid, vecs[i].e_ovf, vecs[i].e_data));
    end
    a_valid_i = 1'b0;
    a_clear_i = 1'b0;

    // 10-bit accumulator: four 511s overflow
    b_valid_i = 1'b1;
    b_data_i  = 9'd511;
    for (int i = 0; i < 4; i++) step();
    check("b_ovf_data", 32'(b_data_o), 32'(B_OVF_SUM));
    check("b_ovf_flag", 32'(b_ovf_o), 32'd1);
    check("b_ovf_valid", 32'(b_valid_o), 32'd1);
    b_valid_i = 1'b0;
    step();
    // Sticky flag must not carry into the next block
    b_valid_i = 1'b1;
    b_data_i  = 9'd1;
    for (int i = 0; i < 4; i++) step();
    check("b_small_data", 32'(b_data_o), 32'd4);
    check("b_small_flag", 32'(b_ovf_o), 32'd0);
    b_valid_i = 1'b0;
    step();

    // ACC_LEN=1: each accept dumps directly
    c_valid_i = 1'b1;
    c_data_i  = 9'd3;
    step();
    check("c_first", {14'b0, c_ready_o, c_valid_o, c_data_o}, {14'b0, 1'b0, 1'b1, 16'd3});
    c_data_i = 9'd300;
    step();
    check("c_bubble", {14'b0, c_ready_o, c_valid_o, c_data_o}, {14'b0, 1'b1, 1'b0, 16'd3});
    step();
    check("c_second", {14'b0, c_ready_o, c_valid_o, c_data_o}, {14'b0, 1'b0, 1'b1, 16'd300});
    check("c_ovf", 32'(c_ovf_o), 32'd0);
    c_valid_i = 1'b0;
    step();

    // Mid-cycle asynchronous reset
    #2 rst_i = 1'b1;
    #1;
    check("midrst_a", pack_a(1'b0, a_valid_o, a_ovf_o, a_data_o), pack_a(1'b0, 1'b0, 1'b0, 16'd0));
    check("midrst_b", {21'b0, b_valid_o, b_data_o}, 32'd0);
    check("midrst_c", {15'b0, c_valid_o, c_data_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    step();
    check("postrst_ready", {29'b0, a_ready_o, b_ready_o, c_ready_o}, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
